alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two-requester front end for an external combinational ALU. At most one
// operation is in flight. Each operation passes through IDLE (grant/accept),
// EXEC (one cycle, the ALU settles on the registered alu_* drive and its
// result is captured) and RESP (response held until rsp_ready).
//
// Arbitration is fixed priority to requester 0. A starvation counter forces
// a grant to requester 1 after STARVE_MAX consecutive requester-0 grants
// taken while requester 1 was waiting.
//
// Optional feature (macro ALU_ARBITER_OVF_STICKY_EN):
//   defined   -> ovf_sticky latches the ALU overflow flag at EXEC capture and
//                is cleared by ovf_clr on a non-capture cycle (set wins).
//   undefined -> ovf_sticky is constant 0 and ovf_clr is ignored.
//
// Parameters
//   STARVE_MAX   max consecutive req0 grants while req1 is waiting
//
// Ports
//   clk                      rising-edge clock
//   rst                      synchronous active-high reset
//   req0_valid/req1_valid    requester N presents an operation
//   req0_ready/req1_ready    operation from requester N accepted this cycle
//   req0_instr/req1_instr    32-bit instruction word (passed through)
//   req0_a/req0_b            requester 0 operands
//   req1_a/req1_b            requester 1 operands
//   alu_instr/alu_a/alu_b    registered drive to the external ALU
//   alu_result/alu_flags     ALU outputs; flags = {zero, negative, overflow}
//   rsp_valid/rsp_ready      response handshake
//   rsp_id                   index of the requester being answered
//   rsp_result/rsp_flags     captured ALU result and flags
//   ovf_clr/ovf_sticky       sticky overflow clear / status
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_instr,
    input  logic [31:0] req1_instr,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] alu_instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_flags,
    input  logic        ovf_clr,
    output logic        ovf_sticky
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic               r_gnt_id;
    logic [31:0]        r_alu_instr;
    logic [31:0]        r_alu_a;
    logic [31:0]        r_alu_b;
    logic               r_rsp_id;
    logic [31:0]        r_rsp_result;
    logic [2:0]         r_rsp_flags;

    logic               w_idle;
    logic               w_starved;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_accept;
    logic               w_capture;

    // Grants exist only in IDLE and never while reset is asserted. Requester 1
    // wins when requester 0 is absent or when requester 1 has been starved.
    assign w_idle    = (r_state == ST_IDLE) && !rst;
    assign w_starved = (r_starve_cnt == STARVE_LIM);
    assign w_grant0  = w_idle && req0_valid && !(req1_valid && w_starved);
    assign w_grant1  = w_idle && req1_valid && (!req0_valid || w_starved);
    // A grant is only issued to a valid requester, so grant == accept.
    assign w_accept  = w_grant0 || w_grant1;
    assign w_capture = (r_state == ST_EXEC);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment first guarantees no latch is inferred for
    // any path through the case statement.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept)  w_state_next = ST_EXEC;
            ST_EXEC:                w_state_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // Acceptance path: operand registers and starvation accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_instr  <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_gnt_id     <= 1'b0;
            r_starve_cnt <= '0;
        end else if (w_accept) begin
            r_alu_instr <= w_grant1 ? req1_instr : req0_instr;
            r_alu_a     <= w_grant1 ? req1_a     : req0_a;
            r_alu_b     <= w_grant1 ? req1_b     : req0_b;
            r_gnt_id    <= w_grant1;
            // Cannot overflow: at STARVE_LIM with req1 waiting, req1 is granted.
            if (w_grant0 && req1_valid) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    // Response capture: one cycle after acceptance the ALU output is settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else if (w_capture) begin
            r_rsp_id     <= r_gnt_id;
            r_rsp_result <= alu_result;
            r_rsp_flags  <= alu_flags;
        end
    end

`ifdef ALU_ARBITER_OVF_STICKY_EN
    logic r_ovf_sticky;

    // A capture cycle never clears; a set therefore always beats ovf_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_capture) begin
            if (alu_flags[0]) begin
                r_ovf_sticky <= 1'b1;
            end
        end else if (ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`else
    logic w_ovf_clr_unused;

    assign w_ovf_clr_unused = ovf_clr;
    assign ovf_sticky       = 1'b0;
`endif

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign alu_instr  = r_alu_instr;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A small combinational ALU (add/sub R-type
// funct codes) stands in for the external ALU. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam logic [31:0] INSTR_ADD = 32'h0001_4020;
    localparam logic [31:0] INSTR_SUB = 32'h0001_4022;

`ifdef ALU_ARBITER_OVF_STICKY_EN
    localparam logic EXP_STICKY = 1'b1;
`else
    localparam logic EXP_STICKY = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [31:0] req0_instr;
    logic [31:0] req1_instr;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [31:0] alu_instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic        ovf_clr;
    logic        ovf_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_instr (req0_instr),
        .req1_instr (req1_instr),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_instr  (alu_instr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: add (funct 0x20) and sub (funct 0x22), signed overflow.
    always_comb begin
        logic [31:0] r;
        logic        ovf;
        r   = '0;
        ovf = 1'b0;
        case (alu_instr[5:0])
            6'h20: begin
                r   = alu_a + alu_b;
                ovf = (alu_a[31] == alu_b[31]) && (r[31] != alu_a[31]);
            end
            6'h22: begin
                r   = alu_a - alu_b;
                ovf = (alu_a[31] != alu_b[31]) && (r[31] != alu_a[31]);
            end
            default: r = '0;
        endcase
        alu_result = r;
        alu_flags  = {(r == 32'd0), r[31], ovf};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 2 time units after it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present an operation, wait (bounded) for its grant, then step past the
    // accepting edge and drop valid.
    task automatic issue(input bit id, input logic [31:0] instr,
                         input logic [31:0] a, input logic [31:0] b);
        int n;
        if (id) begin
            req1_valid = 1'b1; req1_instr = instr; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_instr = instr; req0_a = a; req0_b = b;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            step();
            n++;
        end
        check("issue_grant", {31'd0, (id ? req1_ready : req0_ready)}, 32'd1);
        step();
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid; returns the number of edges waited.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int g;
        int cyc;
        int order [10];
        int gcyc  [10];
        int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_instr = '0; req1_instr = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready  = 1'b1;
        ovf_clr    = 1'b0;

        // ---- reset ----
        step();
        step();
        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_rsp_valid",  {31'd0, rsp_valid}, 32'd0);
        check("rst_alu_instr",  alu_instr, 32'd0);
        check("rst_alu_a",      alu_a, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_ovf",        {31'd0, ovf_sticky}, 32'd0);

        // ---- req0 add 4+5 ----
        issue(1'b0, INSTR_ADD, 32'd4, 32'd5);
        check("t1_alu_instr", alu_instr, INSTR_ADD);
        check("t1_alu_a",     alu_a, 32'd4);
        check("t1_alu_b",     alu_b, 32'd5);
        check("t1_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
        wait_rsp(n);
        check("t1_accept_to_rsp_edges", n + 1, 32'd2);
        check("t1_rsp_id",     {31'd0, rsp_id}, 32'd0);
        check("t1_rsp_result", rsp_result, 32'd9);
        check("t1_rsp_flags",  {29'd0, rsp_flags}, 32'd0);
        step();
        check("t1_back_idle",  {31'd0, rsp_valid}, 32'd0);

        // ---- req1 add with signed overflow ----
        issue(1'b1, INSTR_ADD, 32'h7FFF_FFF8, 32'h7FFF_FFF9);
        wait_rsp(n);
        check("t2_rsp_id",     {31'd0, rsp_id}, 32'd1);
        check("t2_rsp_result", rsp_result, 32'hFFFF_FFF1);
        check("t2_rsp_flags",  {29'd0, rsp_flags}, 32'd3);
        check("t2_sticky_set", {31'd0, ovf_sticky}, {31'd0, EXP_STICKY});
        step();
        step();
        step();
        check("t2_sticky_hold", {31'd0, ovf_sticky}, {31'd0, EXP_STICKY});
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t2_sticky_clr", {31'd0, ovf_sticky}, 32'd0);

        // ---- starvation: both valid continuously ----
        req0_valid = 1'b1; req0_instr = INSTR_ADD; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_instr = INSTR_ADD; req1_a = 32'd2; req1_b = 32'd2;
        #1;
        g = 0;
        cyc = 0;
        while (g < 10 && cyc < 100) begin
            if (req0_ready || req1_ready) begin
                if (req0_ready && req1_ready) begin
                    check("t3_single_grant", 32'd2, 32'd1);
                end
                order[g] = req1_ready ? 1 : 0;
                gcyc[g]  = cyc;
                g++;
            end
            step();
            cyc++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("t3_grant_count", g, 32'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_grant_%0d", i), (i < g) ? order[i] : -1, exp_order[i]);
        end
        check("t3_issue_interval", (g > 1) ? gcyc[1] - gcyc[0] : 0, 32'd3);
        wait_rsp(n);
        check("t3_last_rsp_id", {31'd0, rsp_id}, 32'd1);
        step();

        // ---- backpressure: rsp_ready low for 5 cycles in RESP ----
        rsp_ready = 1'b0;
        issue(1'b0, INSTR_ADD, 32'd10, 32'd20);
        wait_rsp(n);
        req0_valid = 1'b1; req0_instr = INSTR_ADD; req0_a = 32'd100; req0_b = 32'd1;
        req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_hold_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("t4_hold_result_%0d", i), rsp_result, 32'd30);
            check($sformatf("t4_no_ready_%0d", i), {31'd0, req0_ready | req1_ready}, 32'd0);
            step();
        end
        rsp_ready  = 1'b1;
        req1_valid = 1'b0;
        #1;
        check("t4_ready_in_resp", {31'd0, req0_ready}, 32'd0);
        step();
        check("t4_ready_after_release", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        check("t4_next_alu_a", alu_a, 32'd100);
        wait_rsp(n);
        check("t4_next_result", rsp_result, 32'd101);
        step();

        // ---- reset during EXEC ----
        issue(1'b0, INSTR_SUB, 32'd99, 32'd25);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t5_rsp_valid",  {31'd0, rsp_valid}, 32'd0);
        check("t5_alu_instr",  alu_instr, 32'd0);
        check("t5_alu_a",      alu_a, 32'd0);
        check("t5_alu_b",      alu_b, 32'd0);
        check("t5_rsp_result", rsp_result, 32'd0);
        check("t5_rsp_flags",  {29'd0, rsp_flags}, 32'd0);
        check("t5_rsp_id",     {31'd0, rsp_id}, 32'd0);
        check("t5_ovf",        {31'd0, ovf_sticky}, 32'd0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) n++;
            step();
        end
        check("t5_no_response", n, 32'd0);
        issue(1'b0, INSTR_SUB, 32'd99, 32'd25);
        wait_rsp(n);
        check("t5_fresh_result", rsp_result, 32'd74);
        check("t5_fresh_flags",  {29'd0, rsp_flags}, 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
